sa2x2_sched: RTL

//  Job sequencer for the 2x2 output-stationary systolic array (S_Array2x2).

---
 rtl/sa2x2_sched.sv | 197 +++++++++++++++++++
 1 files changed

// File: rtl/sa2x2_sched.sv
// ----------------------------------------------------------------------------
// sa2x2_sched
//   Job sequencer for a 2x2 output-stationary systolic array. The operand
//   matrices A and B are latched when a job is accepted. The array is then
//   cleared, and A rows (west) and B columns (north) are streamed in with a
//   one-cycle skew. The sequencer waits for the pipeline to drain, captures
//   C = A*B and presents it on a valid/ready port. This block is the only
//   driver of the array inputs.
//
//   Optional feature (compile-time macro SA_SCHED_ACCUM_EN):
//     - adds input acc_i, which is sampled together with start_i;
//     - acc_i=1 skips CLEAR, so the array accumulates onto its previous C.
//
// Parameters
//   DATA_W        operand element width
//   ACC_W         result element width
//   DRAIN_CYCLES  zero-input cycles after the last operand, before capture (>=1)
//
// Ports
//   clk_i, rst_ni         clock; asynchronous active-low reset
//   start_i               job request, accepted only when idle
//   acc_i                 accumulate onto the previous C (SA_SCHED_ACCUM_EN only)
//   a_mat_i, b_mat_i      operands {x11,x10,x01,x00}; xRC at [(2R+C)*DATA_W +: DATA_W]
//   busy_o                high from job accept until the result handshake
//   res_valid_o           result available
//   res_ready_i           consumer accepts the result
//   res_mat_o             C, same packing as the operands (ACC_W per element)
//   sa_clr_o              array clear, one cycle per non-accumulating job
//   sa_n0_o, sa_n1_o      array north inputs (column 0 / column 1)
//   sa_w0_o, sa_w1_o      array west inputs (row 0 / row 1)
//   sa_c00_i..sa_c11_i    array accumulator outputs
// ----------------------------------------------------------------------------
module sa2x2_sched #(
    parameter int unsigned DATA_W       = 16,
    parameter int unsigned ACC_W        = 32,
    parameter int unsigned DRAIN_CYCLES = 2
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  start_i,
`ifdef SA_SCHED_ACCUM_EN
    input  logic                  acc_i,
`endif
    input  logic [4*DATA_W-1:0]   a_mat_i,
    input  logic [4*DATA_W-1:0]   b_mat_i,
    output logic                  busy_o,
    output logic                  res_valid_o,
    input  logic                  res_ready_i,
    output logic [4*ACC_W-1:0]    res_mat_o,
    output logic                  sa_clr_o,
    output logic [DATA_W-1:0]     sa_n0_o,
    output logic [DATA_W-1:0]     sa_n1_o,
    output logic [DATA_W-1:0]     sa_w0_o,
    output logic [DATA_W-1:0]     sa_w1_o,
    input  logic [ACC_W-1:0]      sa_c00_i,
    input  logic [ACC_W-1:0]      sa_c01_i,
    input  logic [ACC_W-1:0]      sa_c10_i,
    input  logic [ACC_W-1:0]      sa_c11_i
);

    localparam int unsigned DrainW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

    typedef enum logic [2:0] {StIdle, StClear, StFeed, StDrain, StDone} state_e;

    state_e                state_q;
    logic [2:0]            t_q;
    logic [DrainW-1:0]     d_q;
    logic [4*DATA_W-1:0]   a_q, b_q;
    logic                  busy_q, res_valid_q, sa_clr_q;
    logic [4*ACC_W-1:0]    res_mat_q;
    logic [DATA_W-1:0]     sa_n0_q, sa_n1_q, sa_w0_q, sa_w1_q;

    logic                  acc_req;
    logic                  accept;
    logic                  load;
    logic [2:0]            feed_t;
    logic [4*DATA_W-1:0]   feed_a, feed_b;
    logic [DATA_W-1:0]     n0_nx, n1_nx, w0_nx, w1_nx;

`ifdef SA_SCHED_ACCUM_EN
    assign acc_req = acc_i;
`else
    assign acc_req = 1'b0;
`endif

    function automatic logic [DATA_W-1:0] elem(input logic [4*DATA_W-1:0] m,
                                               input logic r, input logic c);
        return m[int'({r, c}) * DATA_W +: DATA_W];
    endfunction

    assign accept = (state_q == StIdle) && start_i;

    // Operand values for the FEED step being entered on the next edge.
    // When a job is accepted straight into FEED, the operand registers are
    // still loading, so the inputs are used directly.
    always_comb begin
        load   = (accept && acc_req) || (state_q == StClear) ||
                 ((state_q == StFeed) && (t_q != 3'd2));
        feed_t = (state_q == StFeed) ? t_q + 3'd1 : 3'd0;
        feed_a = (state_q == StIdle) ? a_mat_i : a_q;
        feed_b = (state_q == StIdle) ? b_mat_i : b_q;
        w0_nx  = '0;
        w1_nx  = '0;
        n0_nx  = '0;
        n1_nx  = '0;
        if (load) begin
            // feed_t[0] is k for the t<2 lane; feed_t[1] is k=t-1 for the skewed lane
            if (feed_t < 3'd2) begin
                w0_nx = elem(feed_a, 1'b0, feed_t[0]);
                n0_nx = elem(feed_b, feed_t[0], 1'b0);
            end
            if ((feed_t >= 3'd1) && (feed_t <= 3'd2)) begin
                w1_nx = elem(feed_a, 1'b1, feed_t[1]);
                n1_nx = elem(feed_b, feed_t[1], 1'b1);
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= StIdle;
            t_q         <= '0;
            d_q         <= '0;
            a_q         <= '0;
            b_q         <= '0;
            busy_q      <= 1'b0;
            res_valid_q <= 1'b0;
            sa_clr_q    <= 1'b0;
            res_mat_q   <= '0;
            sa_n0_q     <= '0;
            sa_n1_q     <= '0;
            sa_w0_q     <= '0;
            sa_w1_q     <= '0;
        end else begin
            sa_clr_q <= 1'b0;
            sa_w0_q  <= w0_nx;
            sa_w1_q  <= w1_nx;
            sa_n0_q  <= n0_nx;
            sa_n1_q  <= n1_nx;
            case (state_q)
                StIdle: begin
                    if (start_i) begin
                        a_q    <= a_mat_i;
                        b_q    <= b_mat_i;
                        busy_q <= 1'b1;
                        t_q    <= '0;
                        if (acc_req) begin
                            state_q <= StFeed;
                        end else begin
                            state_q  <= StClear;
                            sa_clr_q <= 1'b1;
                        end
                    end
                end
                StClear: begin
                    state_q <= StFeed;
                    t_q     <= '0;
                end
                StFeed: begin
                    if (t_q == 3'd2) begin
                        state_q <= StDrain;
                        d_q     <= '0;
                    end else begin
                        t_q <= t_q + 3'd1;
                    end
                end
                StDrain: begin
                    if (d_q == DrainW'(DRAIN_CYCLES - 1)) begin
                        res_mat_q   <= {sa_c11_i, sa_c10_i, sa_c01_i, sa_c00_i};
                        res_valid_q <= 1'b1;
                        state_q     <= StDone;
                    end else begin
                        d_q <= d_q + 1'b1;
                    end
                end
                StDone: begin
                    if (res_ready_i) begin
                        res_valid_q <= 1'b0;
                        busy_q      <= 1'b0;
                        state_q     <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign busy_o      = busy_q;
    assign res_valid_o = res_valid_q;
    assign res_mat_o   = res_mat_q;
    assign sa_clr_o    = sa_clr_q;
    assign sa_n0_o     = sa_n0_q;
    assign sa_n1_o     = sa_n1_q;
    assign sa_w0_o     = sa_w0_q;
    assign sa_w1_o     = sa_w1_q;

endmodule
